// File: rtl/sar_adc_ctrl.sv
// Successive-approximation controller: runs a binary search on the R2R DAC code
// against an external comparator. Optional comparator synchronizer: SAR_CMP_SYNC_EN.
module sar_adc_ctrl #(
  parameter int WIDTH  = 8,
  parameter int SETTLE = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             cmp_in,
  output logic [WIDTH-1:0] dac_code,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int IDX_W = $clog2(WIDTH);
`ifdef SAR_CMP_SYNC_EN
  // Two extra cycles per bit cover the synchronizer so the sampled value is settled.
  localparam int P = SETTLE + 2;
`else
  localparam int P = SETTLE;
`endif
  localparam logic [7:0] CNT_LAST = 8'(P - 1);

  typedef enum logic {IDLE, CONV} state_t;

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic [7:0]       cnt;
  logic             cmp_s;
  logic [WIDTH-1:0] code_dec;

`ifdef SAR_CMP_SYNC_EN
  logic cmp_m, cmp_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmp_m <= 1'b0;
      cmp_q <= 1'b0;
    end else begin
      cmp_m <= cmp_in;
      cmp_q <= cmp_m;
    end
  end

  assign cmp_s = cmp_q;
`else
  assign cmp_s = cmp_in;
`endif

  // Code after a decision: resolve the current trial bit, arm the next one.
  always_comb begin
    code_dec      = dac_code;
    code_dec[idx] = ~cmp_s;
    if (idx != '0)
      code_dec[idx - 1'b1] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      idx      <= '0;
      cnt      <= '0;
      dac_code <= '0;
      result   <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state    <= CONV;
            idx      <= IDX_W'(WIDTH - 1);
            cnt      <= '0;
            dac_code <= {1'b1, {(WIDTH-1){1'b0}}};
            busy     <= 1'b1;
          end
        end
        CONV: begin
          if (cnt != CNT_LAST) begin
            cnt <= cnt + 8'd1;
          end else begin
            dac_code <= code_dec;
            if (idx != '0) begin
              idx <= idx - 1'b1;
              cnt <= '0;
            end else begin
              result <= code_dec;
              done   <= 1'b1;
              busy   <= 1'b0;
              state  <= IDLE;
            end
          end
        end
      endcase
    end
  end

endmodule
